hub75_capture: RTL and testbench

Receive-side counterpart of the LED-matrix scan output. Oversamples a HUB75 bus (pixel clock, row latch, #OE, row address A–D, RGB1/RGB2) on `clk_in` and rebuilds each shifted line into a 64-entry buffer. On every row latch it streams the line out as framebuffer writes `{row, column} -> {rgb2, rgb1}` through a valid/ready port. Used for loopback self-test of the matrix driver and for sniffing third-party panel controllers.

---
 rtl/hub75_capture.sv | 211 +++++++++++++++++++++
 tb/tb_hub75_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// hub75_capture: oversampling HUB75 receiver.
// Rebuilds each shifted line into a 64-entry buffer and streams it out as
// framebuffer writes {row, column} -> {rgb2, rgb1} after every row latch.
// Optional build macro HUB75_CAPTURE_LATCH_FILTER_EN: commit on the latch
// falling edge, and only when the latch width is at most LATCH_MAX_TICKS.
module hub75_capture #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic [7:0]  LATCH_MAX_TICKS = 8'd3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       hub_clk_pixel,
  input  logic       hub_row_latch,
  input  logic       hub_output_enable_n,
  input  logic [3:0] hub_row_address,
  input  logic [2:0] hub_rgb1,
  input  logic [2:0] hub_rgb2,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [9:0] wr_address,
  output logic [5:0] wr_data,
  output logic [7:0] line_count,
  output logic       overrun,
  output logic       oe_active,
  output logic       busy
);
  localparam int unsigned COLS  = 64;
  localparam int unsigned BUS_W = 13;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_e;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("hub75_capture: SYNC_STAGES must be at least 2");
  end
  if (LATCH_MAX_TICKS == 8'd0) begin : g_bad_latch
    $error("hub75_capture: LATCH_MAX_TICKS must be nonzero");
  end

  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] sync_q [SYNC_STAGES];
  logic [BUS_W-1:0] sync_d [SYNC_STAGES];
  logic [BUS_W-1:0] s;
  logic             s_pix, s_latch, s_oe_n;
  logic [3:0]       s_row;
  logic [5:0]       s_pixel;

  logic       pix_prev_q, pix_prev_d, latch_prev_q, latch_prev_d;
  logic [6:0] col_ptr_q, col_ptr_d;
  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d, idx_inc;
  logic [3:0] row_q, row_d;
  logic       wr_valid_q, wr_valid_d;
  logic [9:0] wr_address_q, wr_address_d;
  logic [5:0] wr_data_q, wr_data_d;
  logic [7:0] line_count_q, line_count_d;
  logic       overrun_q, overrun_d;
  logic       oe_active_q, oe_active_d;
  logic       busy_q, busy_d;

  logic       shift_we, commit, latch_drop, load_drain;
  logic [5:0] entry0;
  logic [5:0] shift_buf_q [COLS];
  logic [5:0] drain_buf_q [COLS];

  assign bus_in  = {hub_clk_pixel, hub_row_latch, hub_output_enable_n,
                    hub_row_address, hub_rgb2, hub_rgb1};
  assign s       = sync_q[SYNC_STAGES-1];
  assign s_pix   = s[12];
  assign s_latch = s[11];
  assign s_oe_n  = s[10];
  assign s_row   = s[9:6];
  assign s_pixel = s[5:0];

  // Synchronizer chain next values
  always_comb begin
    for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_d[i] = '0;
    sync_d[0] = bus_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

`ifdef HUB75_CAPTURE_LATCH_FILTER_EN
  logic [7:0] latch_cnt_q, latch_cnt_d;
  logic       latch_fall;

  // Saturating latch-high width counter, cleared while latch is low
  always_comb begin
    latch_cnt_d = '0;
    if (s_latch) latch_cnt_d = (latch_cnt_q == 8'hFF) ? latch_cnt_q : latch_cnt_q + 8'd1;
  end

  // Width counter register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) latch_cnt_q <= '0;
    else        latch_cnt_q <= latch_cnt_d;
  end

  assign latch_fall = latch_prev_q & ~s_latch;
  assign commit     = latch_fall & (latch_cnt_q <= LATCH_MAX_TICKS);
  assign latch_drop = latch_fall & (latch_cnt_q > LATCH_MAX_TICKS);
`else
  assign commit     = s_latch & ~latch_prev_q;
  assign latch_drop = 1'b0;
`endif

  assign shift_we   = s_pix & ~pix_prev_q & ~col_ptr_q[6];
  assign load_drain = commit & (state_q == ST_IDLE);
  assign entry0     = (shift_we && col_ptr_q[5:0] == 6'd0) ? s_pixel : shift_buf_q[0];
  assign idx_inc    = idx_q + 6'd1;

  // Line buffers; a pixel coincident with a commit is folded into the copy
  always_ff @(posedge clk_in) begin
    if (shift_we) shift_buf_q[col_ptr_q[5:0]] <= s_pixel;
    if (load_drain) begin
      for (int unsigned i = 0; i < COLS; i++)
        drain_buf_q[i] <= (shift_we && col_ptr_q[5:0] == 6'(i)) ? s_pixel : shift_buf_q[i];
    end
  end

  // Column pointer, drain FSM and registered outputs: next-state logic
  always_comb begin
    pix_prev_d   = s_pix;
    latch_prev_d = s_latch;
    oe_active_d  = ~s_oe_n;
    col_ptr_d    = col_ptr_q;
    state_d      = state_q;
    idx_d        = idx_q;
    row_d        = row_q;
    wr_valid_d   = wr_valid_q;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    line_count_d = line_count_q;
    overrun_d    = overrun_q;

    if (commit || latch_drop) col_ptr_d = '0;
    else if (shift_we)        col_ptr_d = col_ptr_q + 7'd1;

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d      = ST_DRAIN;
          idx_d        = '0;
          row_d        = s_row;
          wr_valid_d   = 1'b1;
          wr_address_d = {s_row, 6'd0};
          wr_data_d    = entry0;
        end
      end
      ST_DRAIN: begin
        if (commit) overrun_d = 1'b1;
        if (wr_valid_q && wr_ready) begin
          if (idx_q == 6'd63) begin
            state_d      = ST_IDLE;
            wr_valid_d   = 1'b0;
            line_count_d = line_count_q + 8'd1;
          end else begin
            idx_d        = idx_inc;
            wr_address_d = {row_q, idx_inc};
            wr_data_d    = drain_buf_q[idx_inc];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRAIN);
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      pix_prev_q   <= 1'b0;
      latch_prev_q <= 1'b0;
      col_ptr_q    <= '0;
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      row_q        <= '0;
      wr_valid_q   <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      line_count_q <= '0;
      overrun_q    <= 1'b0;
      oe_active_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      pix_prev_q   <= pix_prev_d;
      latch_prev_q <= latch_prev_d;
      col_ptr_q    <= col_ptr_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      wr_valid_q   <= wr_valid_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      line_count_q <= line_count_d;
      overrun_q    <= overrun_d;
      oe_active_q  <= oe_active_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign line_count = line_count_q;
  assign overrun    = overrun_q;
  assign oe_active  = oe_active_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Directed testbench for hub75_capture with a passive write-port monitor.
module tb_hub75_capture;
  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pix = 1'b0, latch = 1'b0, oe_n = 1'b1;
  logic [3:0] row = '0;
  logic [2:0] rgb1 = '0, rgb2 = '0;
  logic       wr_ready = 1'b1;
  logic       wr_valid, overrun, oe_active, busy;
  logic [9:0] wr_address;
  logic [5:0] wr_data;
  logic [7:0] line_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] cap_addr[$];
  logic [5:0] cap_data[$];
  logic [5:0] exp_line [64];
  int         busy_cycles = 0;
  bit         bp_en = 1'b0;
  int         bp_phase = 0;
  bit         stall_prev = 1'b0;
  logic [9:0] hold_addr;
  logic [5:0] hold_data;

  hub75_capture #(.SYNC_STAGES(2), .LATCH_MAX_TICKS(8'd3)) dut (
    .clk_in(clk_in), .reset(rst_n),
    .hub_clk_pixel(pix), .hub_row_latch(latch), .hub_output_enable_n(oe_n),
    .hub_row_address(row), .hub_rgb1(rgb1), .hub_rgb2(rgb2),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_address(wr_address), .wr_data(wr_data),
    .line_count(line_count), .overrun(overrun), .oe_active(oe_active), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sink-side ready pattern 1-0-0-1 when backpressure is enabled
  always @(posedge clk_in) begin
    #1;
    if (bp_en) begin
      wr_ready = (bp_phase == 0 || bp_phase == 3);
      bp_phase = (bp_phase + 1) % 4;
    end else begin
      wr_ready = 1'b1;
    end
  end

  // Monitor: record accepted writes, verify stability while stalled
  always @(negedge clk_in) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (stall_prev) begin
        check("stall_valid", wr_valid, 1);
        check("stall_addr", wr_address, hold_addr);
        check("stall_data", wr_data, hold_data);
      end
      if (wr_valid && wr_ready) begin
        cap_addr.push_back(wr_address);
        cap_data.push_back(wr_data);
      end
      stall_prev = wr_valid && !wr_ready;
      hold_addr  = wr_address;
      hold_data  = wr_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_pixel(input logic [5:0] d);
    {rgb2, rgb1} = d;
    tick(3);
    pix = 1'b1;
    tick(3);
    pix = 1'b0;
  endtask

  task automatic send_latch(input logic [3:0] r, input int width);
    row = r;
    tick(1);
    latch = 1'b1;
    tick(width);
    latch = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    tick(8);
    while ((busy || wr_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    tick(2);
    if (n >= 3000) check({tag, "_timeout_busy"}, busy, 0);
  endtask

  task automatic verify_line(input string tag, input logic [3:0] r);
    check({tag, "_count"}, cap_addr.size(), 64);
    for (int c = 0; c < 64; c++) begin
      if (c < cap_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, c), cap_addr[c], {r, 6'(c)});
        check($sformatf("%s_data%0d", tag, c), cap_data[c], exp_line[c]);
      end
    end
    cap_addr.delete();
    cap_data.delete();
  endtask

  initial begin
    // Reset with random bus activity
    for (int i = 0; i < 12; i++) begin
      {pix, latch, oe_n, row, rgb2, rgb1} = 13'($urandom);
      tick(1);
    end
    @(negedge clk_in);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_address", wr_address, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_line_count", line_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_oe_active", oe_active, 0);
    pix = 0; latch = 0; oe_n = 1; row = 0; rgb1 = 0; rgb2 = 0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("oe_inactive", oe_active, 0);
    oe_n = 1'b0;
    tick(5);
    check("oe_active", oe_active, 1);
    oe_n = 1'b1;
    tick(5);
    check("oe_released", oe_active, 0);

    // Full line, row 5, data = column
    busy_cycles = 0;
    for (int c = 0; c < 64; c++) begin
      send_pixel(6'(c));
      exp_line[c] = 6'(c);
    end
    send_latch(4'd5, 2);
    wait_idle("line1");
    verify_line("line1", 4'd5);
    check("line1_busy_cycles", busy_cycles, 64);
    check("line1_count", line_count, 1);

    // Backpressure 1-0-0-1, row 10
    for (int c = 0; c < 64; c++) begin
      send_pixel(6'(63 - c));
      exp_line[c] = 6'(63 - c);
    end
    bp_phase = 0;
    bp_en = 1'b1;
    send_latch(4'd10, 2);
    wait_idle("bp");
    bp_en = 1'b0;
    tick(2);
    verify_line("bp", 4'd10);
    check("bp_line_count", line_count, 2);
    check("bp_no_overrun", overrun, 0);

    // Overrun: second latch 20 cycles after the first
    for (int c = 0; c < 64; c++) begin
      send_pixel(6'(c) ^ 6'h15);
      exp_line[c] = 6'(c) ^ 6'h15;
    end
    send_latch(4'd1, 2);
    tick(16);
    send_latch(4'd2, 2);
    wait_idle("ovr");
    verify_line("ovr", 4'd1);
    check("ovr_overrun", overrun, 1);
    check("ovr_line_count", line_count, 3);

    // Full line of zeros, then a short line of 10 x 0x3F
    for (int c = 0; c < 64; c++) begin
      send_pixel(6'h00);
      exp_line[c] = 6'h00;
    end
    send_latch(4'd3, 2);
    wait_idle("zero");
    verify_line("zero", 4'd3);
    for (int c = 0; c < 10; c++) begin
      send_pixel(6'h3F);
      exp_line[c] = 6'h3F;
    end
    send_latch(4'd4, 2);
    wait_idle("short");
    verify_line("short", 4'd4);
    check("short_line_count", line_count, 5);

    // Long line of 70 pixels: only the first 64 are kept
    for (int c = 0; c < 70; c++) begin
      send_pixel((c < 64) ? 6'(c) : 6'h2A);
      if (c < 64) exp_line[c] = 6'(c);
    end
    send_latch(4'd6, 2);
    wait_idle("long");
    verify_line("long", 4'd6);

    // Pixel edge coincident with the latch edge
    for (int c = 0; c < 4; c++) begin
      send_pixel(6'h21);
      exp_line[c] = 6'h21;
    end
    exp_line[4] = 6'h33;
    {rgb2, rgb1} = 6'h33;
    row = 4'd7;
    tick(3);
    pix = 1'b1;
    latch = 1'b1;
    tick(3);
    pix = 1'b0;
    latch = 1'b0;
    tick(2);
    wait_idle("coin");
    verify_line("coin", 4'd7);
    send_pixel(6'h0C);
    exp_line[0] = 6'h0C;
    send_latch(4'd8, 2);
    wait_idle("after_coin");
    verify_line("after_coin", 4'd8);
    check("coin_line_count", line_count, 8);

`ifdef HUB75_CAPTURE_LATCH_FILTER_EN
    // Latch width filter: 3 cycles commits, 12 cycles is rejected
    send_pixel(6'h05);
    exp_line[0] = 6'h05;
    send_latch(4'd9, 3);
    wait_idle("flt3");
    verify_line("flt3", 4'd9);
    check("flt3_line_count", line_count, 9);
    send_pixel(6'h1E);
    send_latch(4'd11, 12);
    tick(20);
    check("flt12_no_valid", wr_valid, 0);
    check("flt12_no_writes", cap_addr.size(), 0);
    check("flt12_line_count", line_count, 9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
